// File: rtl/rs_pkg.sv
// Shared GF(256) definitions for the 4-parity Reed-Solomon receive path.
// Field polynomial 0x11d, primitive element alpha = 0x02.
package rs_pkg;

  localparam logic [8:0] GF_POLY = 9'h11d;
  localparam int         NSYM    = 4;

  typedef logic [7:0] sym_t;

  localparam sym_t ALPHA_POW [0:15] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
    8'h1d, 8'h3a, 8'h74, 8'he8, 8'hcd, 8'h87, 8'h13, 8'h26
  };

  // Multiply by alpha: shift left, fold the x^8 term back with the field polynomial.
  function automatic sym_t gf_xtime(input sym_t a);
    sym_t r;
    r = {a[6:0], 1'b0};
    if (a[7]) begin
      r = r ^ GF_POLY[7:0];
    end else begin
      r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_gfmul_alpha.sv
// Combinational GF(256) multiply of one symbol by the constant alpha^POWER.
module rs_gfmul_alpha
  import rs_pkg::*;
#(
  parameter int POWER = 1
) (
  input  logic [7:0] a_i,
  output logic [7:0] p_o
);

  // Repeated xtime; POWER is a constant so this unrolls into a fixed XOR network.
  always_comb begin
    p_o = a_i;
    for (int i = 0; i < POWER; i++) begin
      p_o = gf_xtime(p_o);
    end
  end

endmodule

// File: rtl/rs_syndrome.sv
// Horner-form syndrome calculator S_j = r(alpha^j), j = 0..3, for a streamed
// RS(n, n-4) codeword, highest-degree symbol first, with length checking.
module rs_syndrome
  import rs_pkg::*;
#(
  parameter int MAX_LEN = 255
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       in_valid,
  input  logic       in_last,
  input  logic [7:0] in_data,
  output logic [7:0] synd0,
  output logic [7:0] synd1,
  output logic [7:0] synd2,
  output logic [7:0] synd3,
  output logic       synd_valid,
  output logic       synd_nz,
  output logic       len_err,
  output logic [8:0] frame_len
);

  localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);
  localparam logic [8:0] CNT_SAT   = 9'd256;
  localparam logic [8:0] MIN_LEN   = 9'd5;

  logic [NSYM-1:0][7:0] acc_q, acc_d, acc_mul_s;
  logic [NSYM-1:0][7:0] synd_q, synd_d;
  logic [8:0]           cnt_q, cnt_d;
  logic [8:0]           frame_len_q, frame_len_d;
  logic                 first_q, first_d;
  logic                 synd_valid_q, synd_valid_d;
  logic                 synd_nz_q, synd_nz_d;
  logic                 len_err_q, len_err_d;

  assign acc_mul_s[0] = acc_q[0];

  for (genvar j = 1; j < NSYM; j++) begin : g_mul
    rs_gfmul_alpha #(.POWER(j)) u_mul (
      .a_i (acc_q[j]),
      .p_o (acc_mul_s[j])
    );
  end

  // Next-state: Horner step per accepted symbol, result capture on in_last.
  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    first_d      = first_q;
    synd_d       = synd_q;
    synd_valid_d = 1'b0;
    synd_nz_d    = synd_nz_q;
    len_err_d    = len_err_q;
    frame_len_d  = frame_len_q;
    if (in_valid) begin
      for (int j = 0; j < NSYM; j++) begin
        acc_d[j] = first_q ? in_data : (acc_mul_s[j] ^ in_data);
      end
      if (first_q) begin
        cnt_d = 9'd1;
      end else if (cnt_q == CNT_SAT) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + 9'd1;
      end
      if (in_last) begin
        synd_d       = acc_d;
        synd_valid_d = 1'b1;
        synd_nz_d    = |acc_d;
        len_err_d    = (cnt_d < MIN_LEN) || (cnt_d > MAX_LEN_W);
        frame_len_d  = cnt_d;
        first_d      = 1'b1;
      end else begin
        first_d      = 1'b0;
      end
    end else begin
      first_d = first_q;
    end
  end

  // State and output registers; reset discards any partial codeword.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc_q        <= '0;
      cnt_q        <= 9'd0;
      first_q      <= 1'b1;
      synd_q       <= '0;
      synd_valid_q <= 1'b0;
      synd_nz_q    <= 1'b0;
      len_err_q    <= 1'b0;
      frame_len_q  <= 9'd0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      first_q      <= first_d;
      synd_q       <= synd_d;
      synd_valid_q <= synd_valid_d;
      synd_nz_q    <= synd_nz_d;
      len_err_q    <= len_err_d;
      frame_len_q  <= frame_len_d;
    end
  end

  assign synd0      = synd_q[0];
  assign synd1      = synd_q[1];
  assign synd2      = synd_q[2];
  assign synd3      = synd_q[3];
  assign synd_valid = synd_valid_q;
  assign synd_nz    = synd_nz_q;
  assign len_err    = len_err_q;
  assign frame_len  = frame_len_q;

endmodule
